// File: rtl/fifo_buffer.sv
// fifo_buffer: single-clock FIFO (DEPTH=2**ADDR_WIDTH) with registered read data, count, threshold flags, sticky errors
module fifo_buffer #(
  parameter int DATA_WIDTH = 15,
  parameter int ADDR_WIDTH = 3,
  parameter int AF_LEVEL = 6,
  parameter int AE_LEVEL = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] dataIn,
  input  logic                  wen,
  input  logic                  ren,
  input  logic                  clearErr,
  output logic [DATA_WIDTH-1:0] dataOut,
  output logic                  valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almostFull,
  output logic                  almostEmpty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] ONE = 1;
  localparam logic [ADDR_WIDTH:0] FULL_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] AF_CNT = AF_LEVEL[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AE_CNT = AE_LEVEL[ADDR_WIDTH:0];
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH:0] wr_ptr, rd_ptr;
  logic wr_acc, rd_acc;
  always_comb begin
    full = count == FULL_CNT;
    empty = count == '0;
    almostFull = count >= AF_CNT;
    almostEmpty = count <= AE_CNT;
    rd_acc = ren && !empty;
    wr_acc = wen && (!full || rd_acc);
  end
  always_ff @(posedge clock)
    if (wr_acc && !reset) mem[wr_ptr[ADDR_WIDTH-1:0]] <= dataIn;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      dataOut <= '0;
      valid <= 1'b0;
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ONE;
      if (rd_acc) rd_ptr <= rd_ptr + ONE;
      if (rd_acc) dataOut <= mem[rd_ptr[ADDR_WIDTH-1:0]];
      valid <= rd_acc;
      count <= wr_acc && !rd_acc ? count + ONE : rd_acc && !wr_acc ? count - ONE : count;
      overflow <= wen && !wr_acc ? 1'b1 : clearErr ? 1'b0 : overflow;
      underflow <= ren && !rd_acc ? 1'b1 : clearErr ? 1'b0 : underflow;
    end
endmodule

// File: tb/tb_fifo_buffer.sv
// tb_fifo_buffer: scoreboard bench for fifo_buffer with default parameters
module tb_fifo_buffer;
  logic clock = 1'b0;
  logic reset, wen, ren, clearErr;
  logic [14:0] dataIn, dataOut;
  logic valid, full, empty, almostFull, almostEmpty, overflow, underflow;
  logic [3:0] count;
  int total = 0;
  int bad = 0;
  int mc = 0;
  logic [14:0] mq[$];
  logic [14:0] exp_dout;
  logic exp_valid, exp_ov, exp_un;
  fifo_buffer dut (
    .clock(clock), .reset(reset), .dataIn(dataIn), .wen(wen), .ren(ren), .clearErr(clearErr),
    .dataOut(dataOut), .valid(valid), .full(full), .empty(empty), .almostFull(almostFull),
    .almostEmpty(almostEmpty), .count(count), .overflow(overflow), .underflow(underflow)
  );
  always #5 clock = ~clock;
  task automatic model_reset();
    mq.delete();
    mc = 0;
    exp_dout = '0;
    exp_valid = 1'b0;
    exp_ov = 1'b0;
    exp_un = 1'b0;
  endtask
  task automatic step(input logic w, input logic r, input logic [14:0] d, input logic c);
    logic ra, wa;
    wen = w;
    ren = r;
    dataIn = d;
    clearErr = c;
    ra = r && mc != 0;
    wa = w && (mc != 8 || ra);
    @(posedge clock);
    #1;
    if (ra) exp_dout = mq.pop_front();
    exp_valid = ra;
    if (wa) mq.push_back(d);
    mc = mc + int'(wa) - int'(ra);
    exp_ov = (w && !wa) ? 1'b1 : c ? 1'b0 : exp_ov;
    exp_un = (r && !ra) ? 1'b1 : c ? 1'b0 : exp_un;
    wen = 1'b0;
    ren = 1'b0;
    clearErr = 1'b0;
  endtask
  task automatic test_reset();
    reset = 1'b1;
    wen = 1'b0;
    ren = 1'b0;
    clearErr = 1'b0;
    dataIn = '0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    total++; if (count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", count); end
    total++; if ({empty, full, almostEmpty, almostFull} !== 4'b1010) begin bad++; $display("FAIL reset_flags got=%b want=1010", {empty, full, almostEmpty, almostFull}); end
    total++; if ({valid, overflow, underflow, dataOut} !== 18'd0) begin bad++; $display("FAIL reset_outs got=%b/%b/%b/%h want=0", valid, overflow, underflow, dataOut); end
    reset = 1'b0;
    #1;
  endtask
  task automatic test_fill();
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 1'b0, 15'(i), 1'b0);
      total++; if (count !== mc[3:0]) begin bad++; $display("FAIL fill_count got=%0d want=%0d", count, mc); end
      total++; if (almostFull !== (i >= 6) || full !== (i == 8) || empty !== 1'b0 || almostEmpty !== (i <= 2)) begin bad++; $display("FAIL fill_flags i=%0d got af=%b f=%b e=%b ae=%b", i, almostFull, full, empty, almostEmpty); end
    end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL fill_overflow got=%b want=0", overflow); end
  endtask
  task automatic test_overflow();
    step(1'b1, 1'b0, 15'h7FFF, 1'b0);
    total++; if (overflow !== 1'b1 || count !== 4'd8) begin bad++; $display("FAIL ovf_set got ov=%b cnt=%0d want ov=1 cnt=8", overflow, count); end
    step(1'b0, 1'b0, 15'h0, 1'b1);
    total++; if (overflow !== 1'b0 || overflow !== exp_ov) begin bad++; $display("FAIL ovf_clear got=%b want=0", overflow); end
  endtask
  task automatic test_drain();
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 1'b1, 15'h0, 1'b0);
      total++; if (dataOut !== exp_dout || dataOut !== 15'(i) || valid !== 1'b1) begin bad++; $display("FAIL drain_data i=%0d got=%h v=%b want=%h v=1", i, dataOut, valid, exp_dout); end
    end
    total++; if (empty !== 1'b1 || count !== 4'd0) begin bad++; $display("FAIL drain_empty got e=%b cnt=%0d want e=1 cnt=0", empty, count); end
    step(1'b0, 1'b1, 15'h0, 1'b0);
    total++; if (underflow !== 1'b1 || valid !== 1'b0 || dataOut !== 15'd8) begin bad++; $display("FAIL underflow got un=%b v=%b d=%h want un=1 v=0 d=0008", underflow, valid, dataOut); end
    step(1'b0, 1'b0, 15'h0, 1'b1);
    total++; if (underflow !== exp_un) begin bad++; $display("FAIL un_clear got=%b want=%b", underflow, exp_un); end
  endtask
  task automatic test_full_rw();
    for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, 15'(i + 16), 1'b0);
    step(1'b1, 1'b1, 15'h0AA, 1'b0);
    total++; if (count !== 4'd8 || dataOut !== 15'd17 || valid !== 1'b1 || overflow !== 1'b0) begin bad++; $display("FAIL full_rw got cnt=%0d d=%h v=%b ov=%b want 8/0011/1/0", count, dataOut, valid, overflow); end
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 15'h0, 1'b0);
      total++; if (dataOut !== exp_dout || valid !== exp_valid) begin bad++; $display("FAIL full_rw_drain got=%h want=%h", dataOut, exp_dout); end
    end
    total++; if (dataOut !== 15'h0AA || empty !== 1'b1) begin bad++; $display("FAIL full_rw_last got=%h e=%b want=00aa e=1", dataOut, empty); end
  endtask
  task automatic test_empty_rw_wrap();
    step(1'b1, 1'b1, 15'h055, 1'b0);
    total++; if (count !== 4'd1 || underflow !== 1'b1 || valid !== 1'b0) begin bad++; $display("FAIL empty_rw got cnt=%0d un=%b v=%b want 1/1/0", count, underflow, valid); end
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1, 15'(16'h100 + i), 1'b0);
      total++; if (dataOut !== exp_dout || valid !== 1'b1 || count !== 4'd1) begin bad++; $display("FAIL wrap i=%0d got=%h v=%b cnt=%0d want=%h", i, dataOut, valid, count, exp_dout); end
    end
    step(1'b0, 1'b1, 15'h0, 1'b0);
    total++; if (dataOut !== 15'h113 || count !== 4'd0 || empty !== 1'b1) begin bad++; $display("FAIL wrap_end got=%h cnt=%0d want=0113 cnt=0", dataOut, count); end
  endtask
  task automatic test_async_reset();
    step(1'b0, 1'b0, 15'h0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 15'(16'h200 + i), 1'b0);
    step(1'b0, 1'b1, 15'h0, 1'b0);
    step(1'b1, 1'b0, 15'h205, 1'b0);
    wen = 1'b1;
    dataIn = 15'h7777;
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    total++; if (count !== 4'd0 || {empty, full, almostEmpty, almostFull} !== 4'b1010) begin bad++; $display("FAIL async_flags got cnt=%0d flags=%b want 0/1010", count, {empty, full, almostEmpty, almostFull}); end
    total++; if ({valid, overflow, underflow, dataOut} !== 18'd0) begin bad++; $display("FAIL async_outs got v=%b d=%h", valid, dataOut); end
    reset = 1'b0;
    wen = 1'b0;
    step(1'b1, 1'b0, 15'h321, 1'b0);
    step(1'b0, 1'b1, 15'h0, 1'b0);
    total++; if (dataOut !== 15'h321 || dataOut !== exp_dout || valid !== 1'b1 || count !== 4'd0) begin bad++; $display("FAIL post_reset got=%h v=%b cnt=%0d want=0321", dataOut, valid, count); end
  endtask
  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_drain();
    test_full_rw();
    test_empty_rw_wrap();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fifo_buffer.md
# fifo_buffer

Parametrised synchronous FIFO with integrated storage, pointer management, occupancy count, almost-full/almost-empty thresholds and sticky overflow/underflow error flags. Successor to the fixed 15-bit, 8-entry memory used by the FIFO datapath. Producers and consumers attach directly to it without external pointer logic. It is a single-clock block; read data is registered with one-cycle latency.

## Interface
- DATA_WIDTH, 15: width of each stored word.
- ADDR_WIDTH, 3: address bits. DEPTH = 2**ADDR_WIDTH entries (default 8).
- AF_LEVEL, 6: almostFull asserts when count >= AF_LEVEL. Legal range 1..DEPTH.
- AE_LEVEL, 2: almostEmpty asserts when count <= AE_LEVEL. Legal range 0..DEPTH-1.

Ports:
- clock  in  1  Rising-edge clock for all state.
- reset  in  1  Asynchronous, active-high reset.
- dataIn  in  DATA_WIDTH  Write data.
- wen  in  1  Write request.
- ren  in  1  Read request.
- clearErr  in  1  Synchronous clear of overflow/underflow.
- dataOut  out  DATA_WIDTH  Registered read data.
- valid  out  1  dataOut was loaded by the read accepted on the previous edge.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almostFull  out  1  count >= AF_LEVEL.
- almostEmpty  out  1  count <= AE_LEVEL.
- count  out  ADDR_WIDTH+1  Current occupancy, 0..DEPTH.
- overflow  out  1  Sticky flag: a write was rejected.
- underflow  out  1  Sticky flag: a read was rejected.

## Operation
- Storage is DEPTH x DATA_WIDTH. Contents are not reset or initialised.
- wrPtr and rdPtr are ADDR_WIDTH+1 bits wide.
  - The low ADDR_WIDTH bits index memory.
  - Increments wrap modulo 2**(ADDR_WIDTH+1) with no special case.
- rdAcc = ren && !empty.
- wrAcc = wen && (!full || rdAcc).
  - When full, a simultaneous write is accepted only if a read is accepted in the same cycle.
  - When empty, a simultaneous read is rejected; there is no fall-through. The write is accepted.
- On wrAcc: mem[wrPtr] <= dataIn, wrPtr++.
- On rdAcc: dataOut <= mem[rdPtr], rdPtr++, valid <= 1. Otherwise valid <= 0 and dataOut holds its value.
- Count update:
  - count <= count + wrAcc - rdAcc.
  - A simultaneous accepted read and write leaves count unchanged.
  - count is maintained as a register and must always equal wrPtr - rdPtr (modulo 2**(ADDR_WIDTH+1)).
- full, empty, almostFull and almostEmpty are combinational decodes of the count register only. There are no combinational paths from wen or ren.
- overflow <= 1 when wen && !wrAcc. underflow <= 1 when ren && !rdAcc.
  - Both are cleared by clearErr.
  - If a new error and clearErr occur in the same cycle, the flag ends set.
- The same-address case (reading the entry being written this cycle) cannot occur, because empty blocks that read. No bypass is required.

## Timing
- Reset (asynchronous, immediate):
  - wrPtr=0, rdPtr=0, count=0, dataOut=0, valid=0, overflow=0, underflow=0.
  - Resulting flags: empty=1, full=0, almostEmpty=1 (if AE_LEVEL>=0), almostFull=0.
- Reset asserted mid-transfer aborts the transfer.
  - No partial pointer update survives.
  - Memory contents are left as-is but become unreachable.
- Write-to-visible latency: a word written at edge N raises count and drops empty after edge N. It can be read by a ren presented in cycle N+1, and appears on dataOut after edge N+2.
- Read latency: ren accepted at edge N gives dataOut and valid=1 after edge N, valid for one cycle.
- Flags and count reflect all operations accepted up to and including the most recent edge.
- Back-to-back reads or writes at full rate (one per cycle) are required.

## Test plan
- Reset, then write 1..8 on consecutive cycles with defaults → count steps to 8; almostFull rises after the 6th write; full=1 after the 8th; overflow=0.
- From full, wen=1 with dataIn=0x7FFF, ren=0 → write rejected, overflow=1, count stays 8. Then clearErr=1 → overflow=0.
- Read 8 words back to back → dataOut sequence 1..8, each with valid=1 one cycle after its ren; empty=1 after the 8th read. A 9th ren → underflow=1, valid=0, dataOut holds 8.
- While full, wen=1 and ren=1 with dataIn=0x0AA → both accepted, count stays 8, dataOut equals the oldest word. After draining, 0x0AA emerges last.
- Empty FIFO, wen=1 and ren=1 → write accepted, read rejected, count=1, underflow=1. Then run 20 write/read cycles to force pointer wrap → data order is preserved and count returns to 0.
- Assert reset asynchronously mid-stream with count=5 → all outputs reach their reset values before the next clock edge. The next write/read pair returns the new data, not stale entries.
